muxn_stage: RTL and testbench
=============================

# muxn_stage

Parametrised, registered N-way datapath select stage: the successor to the fixed three-input 32-bit operand mux in the pipelined processor. It picks one of NUM_IN WIDTH-bit inputs by binary index, captures the result in a pipeline register with valid/stall/flush control, and detects illegal select codes instead of leaving the output undefined. It sits at the ALU operand and forwarding points, where it drives the next pipeline stage directly.

## Interface
- WIDTH, 32: data width of each input and of y.
- NUM_IN, 3: number of data inputs, 2..16.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= NUM_IN.
- ERR_W, 8: width of the illegal-select counter.
- clk  input  1  the only clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input i is in_bus[i*WIDTH +: WIDTH].
- sel  input  SEL_W  binary index of the selected input.
- in_valid  input  1  the current sel/in_bus pair is a real transfer.
- stall  input  1  hold the stage; nothing is captured.
- flush  input  1  kill the stage contents.
- err_clr  input  1  clear err_sticky and err_count.
- y  output  WIDTH  registered selected data.
- out_valid  output  1  y holds a valid transfer.
- err_sticky  output  1  set on any illegal select; cleared by err_clr or reset.
- err_count  output  ERR_W  saturating count of illegal selects.

## Operation
- A select is legal when sel < NUM_IN. A transfer event is in_valid=1 with stall=0 and flush=0.
- Each cycle the stage applies the first matching rule below, in priority order:
  - reset: y=0, out_valid=0, err_sticky=0, err_count=0.
  - flush: out_valid goes to 0, y holds. Flush overrides stall.
  - stall: y and out_valid both hold.
  - transfer event with a legal sel: y takes input[sel], out_valid goes to 1.
  - transfer event with an illegal sel: y holds, out_valid goes to 0, err_sticky goes to 1, err_count increments.
  - in_valid=0: out_valid goes to 0, y holds.
- sel is ignored when in_valid=0, stall=1 or flush=1, so no error is counted in those cases.
- err_count saturates at 2**ERR_W-1 and never wraps.
- err_clr is applied before the increment in the same cycle. err_clr together with an illegal transfer leaves err_count=1 and err_sticky=1.
- err_clr is independent of stall and flush.
- The output is never X: there is no latch, and every code, including an illegal one, has defined behaviour.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on y/out_valid after edge k.
- The next stage samples y whenever out_valid=1.
- Throughput is one transfer per cycle when stall=0.
- stall is combinational into the register enable; there is no skid buffer.
- Upstream must hold in_bus/sel/in_valid while stall=1 if it wants the data taken later.
- Error outputs update on the same edge as the illegal transfer. err_sticky rises 1 cycle after the offending sel is presented.
- Reset asserted mid-stream clears everything on that edge. The first capture can happen on the edge after reset deasserts.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MUXN_STAGE_ERRCHK_EN defined:
  - Illegal-select detection, err_sticky and err_count are implemented as described above.
- MUXN_STAGE_ERRCHK_EN undefined:
  - No detection logic is built. err_sticky and err_count are tied to 0, and err_clr is ignored.
  - An illegal sel on a transfer event loads y=0 with out_valid=1, the cheap decode default.
  - Everything else is unchanged.

## Test plan
- Legal selects (NUM_IN=3, WIDTH=32; inputs 0xAAAA0000, 0x0000BBBB, 0x12345678): sel=0,1,2 with in_valid=1 on consecutive cycles -> y=0xAAAA0000, 0x0000BBBB, 0x12345678 on the next three cycles, out_valid=1 throughout.
- Stall then flush: capture 0x0000BBBB, then stall=1 for 3 cycles while sel changes -> y stays 0x0000BBBB with out_valid=1; then flush=1 with stall=1 -> out_valid=0, y still 0x0000BBBB.
- Illegal select, checking enabled: sel=3 with in_valid=1 -> out_valid=0, y holds, err_sticky=1, err_count=1. sel=3 with in_valid=0 -> err_count stays 1.
- Saturation and clear: ERR_W=2, five illegal transfers -> err_count=3. Then err_clr together with an illegal transfer -> err_count=1, err_sticky=1. Then err_clr alone -> 0/0.
- Reset mid-stream: reset=1 while out_valid=1 and y=0x12345678 -> next cycle y=0, out_valid=0, err outputs 0. A legal transfer on the cycle after reset drops -> captured one cycle later.
- Checking compiled out: sel=3 with in_valid=1 -> y=0, out_valid=1, err_count=0, err_sticky=0. Random legal traffic matches a reference model.

Source files
------------

// File: rtl/muxn_stage.sv
// Registered N-way select stage with valid/stall/flush and illegal-select detection.
// Define MUXN_STAGE_ERRCHK_EN to build the error detector (err_sticky/err_count).
module muxn_stage #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int ERR_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        y,
  output logic                    out_valid,
  output logic                    err_sticky,
  output logic [ERR_W-1:0]        err_count
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_legal;
  logic             xfer;

  // Unmatched codes leave sel_data at zero, which is the decode default.
  always_comb begin
    sel_data  = '0;
    sel_legal = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data  = in_bus[i*WIDTH +: WIDTH];
        sel_legal = 1'b1;
      end
    end
  end

  assign xfer = in_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (stall) begin
      y         <= y;
      out_valid <= out_valid;
    end else if (in_valid) begin
      if (sel_legal) begin
        y         <= sel_data;
        out_valid <= 1'b1;
      end else begin
`ifdef MUXN_STAGE_ERRCHK_EN
        out_valid <= 1'b0;
`else
        y         <= '0;
        out_valid <= 1'b1;
`endif
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUXN_STAGE_ERRCHK_EN
  logic xfer_illegal;

  assign xfer_illegal = xfer & ~sel_legal;

  // Clear takes effect first, so a simultaneous illegal transfer counts as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_clr) begin
      err_sticky <= xfer_illegal;
      err_count  <= xfer_illegal ? ERR_W'(1) : '0;
    end else if (xfer_illegal) begin
      err_sticky <= 1'b1;
      if (err_count != {ERR_W{1'b1}})
        err_count <= err_count + ERR_W'(1);
    end
  end
`else
  logic unused_err;

  assign unused_err = err_clr ^ xfer;
  assign err_sticky = 1'b0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_muxn_stage.sv
// Directed and model-checked bench for muxn_stage (NUM_IN=3, WIDTH=32, ERR_W=2).
module tb_muxn_stage;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;
  localparam int ERR_W  = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic                    err_clr;
  logic [WIDTH-1:0]        y;
  logic                    out_valid;
  logic                    err_sticky;
  logic [ERR_W-1:0]        err_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muxn_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr), .y(y), .out_valid(out_valid),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; sel = 0; in_valid = 0; stall = 0; flush = 0; err_clr = 0;
    in_bus = {32'h12345678, 32'h0000BBBB, 32'hAAAA0000};
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; in_valid = 1; sel = 1;
    step();
    vectors++;
    if (y !== 32'h0 || out_valid !== 1'b0 || err_sticky !== 1'b0 || err_count !== 2'd0) begin
      miscompares++;
      $display("FAIL reset: y=%h ov=%b st=%b cnt=%0d, want 0/0/0/0", y, out_valid, err_sticky, err_count);
    end
    idle_inputs();
  endtask

  task automatic test_legal();
    logic [31:0] exp_y [3];
    exp_y[0] = 32'hAAAA0000; exp_y[1] = 32'h0000BBBB; exp_y[2] = 32'h12345678;
    idle_inputs();
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sel = SEL_W'(i);
      step();
      vectors++;
      if (y !== exp_y[i] || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL legal_sel%0d: y=%h ov=%b, want %h/1", i, y, out_valid, exp_y[i]);
      end
    end
    in_valid = 0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || y !== 32'h12345678) begin
      miscompares++;
      $display("FAIL idle_drop: y=%h ov=%b, want 12345678/0", y, out_valid);
    end
  endtask

  task automatic test_stall_flush();
    logic [1:0] sels [3];
    sels[0] = 2'd0; sels[1] = 2'd2; sels[2] = 2'd3;
    idle_inputs();
    in_valid = 1; sel = 1;
    step();
    vectors++;
    if (y !== 32'h0000BBBB || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_capture: y=%h ov=%b, want 0000bbbb/1", y, out_valid);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      sel = sels[i];
      step();
      vectors++;
      if (y !== 32'h0000BBBB || out_valid !== 1'b1 || err_count !== 2'd0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: y=%h ov=%b cnt=%0d, want 0000bbbb/1/0", i, y, out_valid, err_count);
      end
    end
    flush = 1; sel = 3;
    step();
    vectors++;
    if (y !== 32'h0000BBBB || out_valid !== 1'b0 || err_count !== 2'd0) begin
      miscompares++;
      $display("FAIL flush_over_stall: y=%h ov=%b cnt=%0d, want 0000bbbb/0/0", y, out_valid, err_count);
    end
    idle_inputs();
  endtask

`ifdef MUXN_STAGE_ERRCHK_EN
  task automatic test_illegal();
    idle_inputs();
    reset = 1; step(); reset = 0;
    in_valid = 1; sel = 2;
    step();
    sel = 3;
    step();
    vectors++;
    if (y !== 32'h12345678 || out_valid !== 1'b0 || err_sticky !== 1'b1 || err_count !== 2'd1) begin
      miscompares++;
      $display("FAIL illegal: y=%h ov=%b st=%b cnt=%0d, want 12345678/0/1/1", y, out_valid, err_sticky, err_count);
    end
    in_valid = 0;
    step();
    vectors++;
    if (err_count !== 2'd1 || err_sticky !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_no_valid: ov=%b st=%b cnt=%0d, want 0/1/1", out_valid, err_sticky, err_count);
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
    err_clr = 1;
    step();
    err_clr = 0;
    in_valid = 1; sel = 3;
    for (int k = 1; k <= 5; k++) begin
      step();
      vectors++;
      if (err_count !== ((k > 3) ? 2'd3 : 2'(k)) || err_sticky !== 1'b1) begin
        miscompares++;
        $display("FAIL saturate%0d: cnt=%0d st=%b, want %0d/1", k, err_count, err_sticky, (k > 3) ? 3 : k);
      end
    end
    err_clr = 1;
    step();
    vectors++;
    if (err_count !== 2'd1 || err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_with_illegal: cnt=%0d st=%b, want 1/1", err_count, err_sticky);
    end
    in_valid = 0; stall = 1;
    step();
    vectors++;
    if (err_count !== 2'd0 || err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_alone: cnt=%0d st=%b, want 0/0", err_count, err_sticky);
    end
    idle_inputs();
  endtask
`else
  task automatic test_illegal_disabled();
    idle_inputs();
    in_valid = 1; sel = 2;
    step();
    sel = 3; err_clr = 1;
    step();
    vectors++;
    if (y !== 32'h0 || out_valid !== 1'b1 || err_sticky !== 1'b0 || err_count !== 2'd0) begin
      miscompares++;
      $display("FAIL illegal_nochk: y=%h ov=%b st=%b cnt=%0d, want 0/1/0/0", y, out_valid, err_sticky, err_count);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_midstream();
    idle_inputs();
    in_valid = 1; sel = 3;
    step();
    sel = 2;
    step();
    vectors++;
    if (y !== 32'h12345678 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: y=%h ov=%b, want 12345678/1", y, out_valid);
    end
    reset = 1; sel = 0; err_clr = 0;
    step();
    vectors++;
    if (y !== 32'h0 || out_valid !== 1'b0 || err_sticky !== 1'b0 || err_count !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_reset: y=%h ov=%b st=%b cnt=%0d, want 0/0/0/0", y, out_valid, err_sticky, err_count);
    end
    reset = 0; sel = 1;
    step();
    vectors++;
    if (y !== 32'h0000BBBB || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: y=%h ov=%b, want 0000bbbb/1", y, out_valid);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] ey;
    logic        ev, est, ill;
    int          ecnt;
    logic [31:0] d [3];
    idle_inputs();
    reset = 1; step(); reset = 0;
    ey = 0; ev = 0; est = 0; ecnt = 0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) d[i] = $urandom;
      in_bus   = {d[2], d[1], d[0]};
      sel      = SEL_W'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 9) < 8);
      stall    = ($urandom_range(0, 9) < 2);
      flush    = ($urandom_range(0, 9) < 1);
      err_clr  = ($urandom_range(0, 19) < 1);
      ill = in_valid && !stall && !flush && (sel >= 2'd3);
      if (flush) ev = 0;
      else if (stall) ev = ev;
      else if (in_valid) begin
        if (sel < 2'd3) begin ey = d[sel]; ev = 1; end
`ifdef MUXN_STAGE_ERRCHK_EN
        else ev = 0;
`else
        else begin ey = 0; ev = 1; end
`endif
      end else ev = 0;
`ifdef MUXN_STAGE_ERRCHK_EN
      if (err_clr) begin est = ill; ecnt = ill ? 1 : 0; end
      else if (ill) begin est = 1; if (ecnt < 3) ecnt++; end
`endif
      step();
      vectors++;
      if (y !== ey || out_valid !== ev || err_sticky !== est || err_count !== 2'(ecnt)) begin
        miscompares++;
        $display("FAIL random%0d: y=%h ov=%b st=%b cnt=%0d, want %h/%b/%b/%0d",
                 n, y, out_valid, err_sticky, err_count, ey, ev, est, ecnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_legal();
    test_stall_flush();
`ifdef MUXN_STAGE_ERRCHK_EN
    test_illegal();
    test_saturation();
`else
    test_illegal_disabled();
`endif
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
